key_debounce_array: RTL

Parametrised multi-channel push-button conditioner that sits between the board key pins and the control/display logic. Each channel synchronises its raw key, rejects bounce shorter than a programmable stability window, and emits a debounced level plus one-cycle press, release and auto-repeat pulses. A registered encoder merges all channels into a single key-event stream with a code, a repeat flag and a multi-press flag.

---
 rtl/key_pkg.sv | 7 +
 rtl/key_debounce_array_if.sv | 21 ++
 rtl/debounce_channel.sv | 96 +++++++++
 rtl/key_debounce_array.sv | 66 ++++++
 4 files changed

// File: rtl/key_pkg.sv
// key_pkg: channel FSM state type and counter width helper shared by the debounce array
package key_pkg;
  typedef enum logic [1:0] {RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK} key_state_t;
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/key_debounce_array_if.sv
// key_debounce_array_if: raw keys in; debounced levels, press/release/repeat pulses and merged key events out
interface key_debounce_array_if #(parameter int N_KEYS = 3);
  localparam int CODE_W = N_KEYS > 1 ? $clog2(N_KEYS) : 1;
  logic [N_KEYS-1:0] key_raw;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_release;
  logic [N_KEYS-1:0] key_repeat;
  logic evt_valid;
  logic [CODE_W-1:0] evt_code;
  logic evt_repeat;
  logic evt_multi;
  modport master (
    output key_raw,
    input key_level, key_press, key_release, key_repeat, evt_valid, evt_code, evt_repeat, evt_multi
  );
  modport slave (
    input key_raw,
    output key_level, key_press, key_release, key_repeat, evt_valid, evt_code, evt_repeat, evt_multi
  );
endinterface

// File: rtl/debounce_channel.sv
// debounce_channel: one key - 2-flop synchroniser, stability/hold counters, debounced level and press/release/repeat pulses
module debounce_channel
  import key_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int HOLD_CYCLES = 50,
  parameter int REPEAT_CYCLES = 20,
  parameter bit REPEAT_EN = 1'b1
) (
  input logic clk,
  input logic rst,
  input logic raw,
  output logic level,
  output logic press_pls,
  output logic release_pls,
  output logic repeat_pls
);
  localparam int SW = cnt_w(STABLE_CYCLES);
  localparam int HW = cnt_w(HOLD_CYCLES);
  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD_CYCLES - REPEAT_CYCLES);
  key_state_t state, state_nx;
  logic sync1, sync2;
  logic [SW-1:0] stab_cnt, stab_nx;
  logic [HW-1:0] hold_cnt, hold_nx;
  logic level_nx, press_nx, release_nx, repeat_nx;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      state <= RELEASED;
      stab_cnt <= '0;
      hold_cnt <= '0;
      level <= 1'b0;
      press_pls <= 1'b0;
      release_pls <= 1'b0;
      repeat_pls <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      state <= state_nx;
      stab_cnt <= stab_nx;
      hold_cnt <= hold_nx;
      level <= level_nx;
      press_pls <= press_nx;
      release_pls <= release_nx;
      repeat_pls <= repeat_nx;
    end
  always_comb begin
    state_nx = state;
    stab_nx = stab_cnt;
    hold_nx = hold_cnt;
    level_nx = level;
    press_nx = 1'b0;
    release_nx = 1'b0;
    repeat_nx = 1'b0;
    case (state)
      RELEASED:
        if (sync2) begin
          state_nx = PRESS_CHK;
          stab_nx = SW'(1);
        end
      PRESS_CHK:
        if (!sync2) begin
          state_nx = RELEASED;
          stab_nx = '0;
        end else if (stab_cnt == STAB_LAST) begin
          state_nx = PRESSED;
          stab_nx = '0;
          hold_nx = '0;
          level_nx = 1'b1;
          press_nx = 1'b1;
        end else stab_nx = stab_cnt + 1'b1;
      PRESSED:
        if (!sync2) begin
          state_nx = RELEASE_CHK;
          stab_nx = SW'(1);
        end else if (REPEAT_EN) begin
          hold_nx = hold_cnt == HOLD_LAST ? HOLD_RELOAD : hold_cnt + 1'b1;
          repeat_nx = hold_cnt == HOLD_LAST;
        end
      RELEASE_CHK:
        if (sync2) begin
          state_nx = PRESSED;
          stab_nx = '0;
        end else if (stab_cnt == STAB_LAST) begin
          state_nx = RELEASED;
          stab_nx = '0;
          level_nx = 1'b0;
          release_nx = 1'b1;
        end else stab_nx = stab_cnt + 1'b1;
      default: state_nx = RELEASED;
    endcase
  end
endmodule

// File: rtl/key_debounce_array.sv
// key_debounce_array: N_KEYS debounce channels plus a registered priority encoder merging press/repeat pulses into key events
module key_debounce_array
  import key_pkg::*;
#(
  parameter int N_KEYS = 3,
  parameter int STABLE_CYCLES = 4,
  parameter int HOLD_CYCLES = 50,
  parameter int REPEAT_CYCLES = 20,
  parameter bit REPEAT_EN = 1'b1
) (
  input logic sys_clk,
  input logic sys_rst,
  key_debounce_array_if.slave bus
);
  localparam int CODE_W = N_KEYS > 1 ? $clog2(N_KEYS) : 1;
  logic [N_KEYS-1:0] level, press, rel, rep, hit;
  logic [CODE_W-1:0] code_nx, evt_code;
  logic [4:0] cnt;
  logic evt_valid, evt_repeat, evt_multi;
  genvar i;
  for (i = 0; i < N_KEYS; i++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .HOLD_CYCLES(HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES),
      .REPEAT_EN(REPEAT_EN)
    ) u_ch (
      .clk(sys_clk),
      .rst(sys_rst),
      .raw(bus.key_raw[i]),
      .level(level[i]),
      .press_pls(press[i]),
      .release_pls(rel[i]),
      .repeat_pls(rep[i])
    );
  end
  assign hit = press | rep;
  always_comb begin
    code_nx = '0;
    cnt = '0;
    for (int k = N_KEYS - 1; k >= 0; k--) begin
      code_nx = (|press ? press[k] : rep[k]) ? CODE_W'(k) : code_nx;
      cnt = cnt + 5'(hit[k]);
    end
  end
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      evt_valid <= 1'b0;
      evt_code <= '0;
      evt_repeat <= 1'b0;
      evt_multi <= 1'b0;
    end else begin
      evt_valid <= |hit;
      evt_code <= code_nx;
      evt_repeat <= ~|press & |rep;
      evt_multi <= cnt > 5'd1;
    end
  assign bus.key_level = level;
  assign bus.key_press = press;
  assign bus.key_release = rel;
  assign bus.key_repeat = rep;
  assign bus.evt_valid = evt_valid;
  assign bus.evt_code = evt_code;
  assign bus.evt_repeat = evt_repeat;
  assign bus.evt_multi = evt_multi;
endmodule
